// File: rtl/bus_arbiter_lv1_lv2_pkg.sv
// Shared types and index helpers for the lv1-lv2 bus arbiter.
// Proc requester index is {core, il}: dl of a core is even, il is odd.
package bus_arbiter_lv1_lv2_pkg;

   localparam int NUM_PROC_REQ = 8;

   typedef enum logic [1:0] {
      P_IDLE    = 2'd0,
      P_GRANT   = 2'd1,
      P_RELEASE = 2'd2
   } proc_state_e;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } snp_state_e;

   function automatic logic [2:0] proc_idx(input logic [1:0] core, input logic il);
      return {core, il};
   endfunction

   function automatic logic [1:0] idx_core(input logic [2:0] idx);
      return idx[2:1];
   endfunction

   function automatic logic [2:0] onehot_to_idx8(input logic [7:0] oh);
      logic [2:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) if (oh[i]) r = 3'(i);
      return r;
   endfunction

   function automatic logic [1:0] onehot_to_idx4(input logic [3:0] oh);
      logic [1:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
      return r;
   endfunction

endpackage

// File: rtl/bus_arbiter_lv1_lv2_rr_pick.sv
// Round-robin picker: one-hot grant for the first requester strictly after ptr.
// N must be a power of two so the pointer sum wraps naturally.
module rr_pick #(
   parameter int N     = 8,
   parameter int PTR_W = 3
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     gnt
);

   always_comb begin
      logic             found;
      logic [PTR_W-1:0] k;
      gnt   = '0;
      found = 1'b0;
      k     = '0;
      for (int i = 1; i <= N; i++) begin
         k = ptr + PTR_W'(i);
         if (!found && req[k]) begin
            gnt[k] = 1'b1;
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter_lv1_lv2.sv
// lv1-lv2 bus arbiter: round-robin proc grant over 8 requesters plus snoop grants.
// Optional grant-hold timeout enabled by defining LV1_LV2_ARB_TIMEOUT_EN.
module bus_arbiter_lv1_lv2
   import bus_arbiter_lv1_lv2_pkg::*;
#(
   parameter int NUM_CORES   = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] bus_lv1_lv2_req_proc_dl,
   input  logic [3:0] bus_lv1_lv2_req_proc_il,
   input  logic [3:0] bus_lv1_lv2_req_snoop,
   output logic [3:0] bus_lv1_lv2_gnt_proc_dl,
   output logic [3:0] bus_lv1_lv2_gnt_proc_il,
   output logic [3:0] bus_lv1_lv2_gnt_snoop,
   output logic       bus_lv1_lv2_gnt_lv2,
   output logic       arb_timeout
);

   proc_state_e             p_state_d, p_state_q;
   snp_state_e              s_state_d, s_state_q;
   logic [NUM_PROC_REQ-1:0] preq, pick_proc, gnt_proc_d, gnt_proc_q;
   logic [3:0]              own_core, snp_eff, pick_snp, gnt_snp_d, gnt_snp_q;
   logic [2:0]              rr_ptr_d, rr_ptr_q;
   logic [1:0]              snp_ptr_d, snp_ptr_q;
   logic                    own_req, snp_held, timeout_hit;
   logic                    unused_params;

   assign unused_params = ^{NUM_CORES[0], TIMEOUT_CYC[0]};

   always_comb begin
      preq     = '0;
      own_core = '0;
      for (int c = 0; c < 4; c++) begin
         preq[proc_idx(2'(c), 1'b0)] = bus_lv1_lv2_req_proc_dl[c];
         preq[proc_idx(2'(c), 1'b1)] = bus_lv1_lv2_req_proc_il[c];
      end
      for (int i = 0; i < NUM_PROC_REQ; i++)
         if (gnt_proc_q[i]) own_core[idx_core(3'(i))] = 1'b1;
   end

   // The owner's own core never competes for a snoop grant.
   assign own_req  = |(preq & gnt_proc_q);
   assign snp_eff  = bus_lv1_lv2_req_snoop & ~own_core;
   assign snp_held = |(bus_lv1_lv2_req_snoop & gnt_snp_q);

   rr_pick #(.N(NUM_PROC_REQ), .PTR_W(3)) u_pick_proc (
      .req (preq),
      .ptr (rr_ptr_q),
      .gnt (pick_proc)
   );

   rr_pick #(.N(4), .PTR_W(2)) u_pick_snp (
      .req (snp_eff),
      .ptr (snp_ptr_q),
      .gnt (pick_snp)
   );

`ifdef LV1_LV2_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] to_cnt_d, to_cnt_q;
   logic            to_flag_d, to_flag_q;

   // Hit on the last allowed grant cycle so the grant is high TIMEOUT_CYC cycles.
   assign timeout_hit = (p_state_q == P_GRANT) && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

   always_comb begin
      to_cnt_d  = ((p_state_q == P_GRANT) && !timeout_hit) ? to_cnt_q + TO_W'(1) : '0;
      to_flag_d = to_flag_q | timeout_hit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt_q  <= '0;
         to_flag_q <= 1'b0;
      end else begin
         to_cnt_q  <= to_cnt_d;
         to_flag_q <= to_flag_d;
      end
   end

   assign arb_timeout = to_flag_q;
`else
   assign timeout_hit = 1'b0;
   assign arb_timeout = 1'b0;
`endif

   always_comb begin
      p_state_d  = p_state_q;
      gnt_proc_d = gnt_proc_q;
      rr_ptr_d   = rr_ptr_q;
      case (p_state_q)
         P_IDLE: begin
            gnt_proc_d = '0;
            if (|preq) begin
               gnt_proc_d = pick_proc;
               rr_ptr_d   = onehot_to_idx8(pick_proc);
               p_state_d  = P_GRANT;
            end
         end
         P_GRANT: begin
            if (timeout_hit || (!own_req && (s_state_q == S_IDLE))) begin
               gnt_proc_d = '0;
               p_state_d  = P_RELEASE;
            end
         end
         default: begin
            gnt_proc_d = '0;
            p_state_d  = P_IDLE;
         end
      endcase
   end

   // A snoop is only granted while the owner still holds the bus next cycle.
   always_comb begin
      s_state_d = s_state_q;
      gnt_snp_d = gnt_snp_q;
      snp_ptr_d = snp_ptr_q;
      if (s_state_q == S_IDLE) begin
         gnt_snp_d = '0;
         if ((p_state_q == P_GRANT) && own_req && !timeout_hit && (|snp_eff)) begin
            gnt_snp_d = pick_snp;
            snp_ptr_d = onehot_to_idx4(pick_snp);
            s_state_d = S_GRANT;
         end
      end else if (!snp_held || timeout_hit) begin
         gnt_snp_d = '0;
         s_state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_state_q  <= P_IDLE;
         s_state_q  <= S_IDLE;
         gnt_proc_q <= '0;
         gnt_snp_q  <= '0;
         rr_ptr_q   <= 3'd7;
         snp_ptr_q  <= 2'd3;
      end else begin
         p_state_q  <= p_state_d;
         s_state_q  <= s_state_d;
         gnt_proc_q <= gnt_proc_d;
         gnt_snp_q  <= gnt_snp_d;
         rr_ptr_q   <= rr_ptr_d;
         snp_ptr_q  <= snp_ptr_d;
      end
   end

   always_comb begin
      for (int c = 0; c < 4; c++) begin
         bus_lv1_lv2_gnt_proc_dl[c] = gnt_proc_q[proc_idx(2'(c), 1'b0)];
         bus_lv1_lv2_gnt_proc_il[c] = gnt_proc_q[proc_idx(2'(c), 1'b1)];
      end
   end

   assign bus_lv1_lv2_gnt_snoop = gnt_snp_q;
   assign bus_lv1_lv2_gnt_lv2   = |gnt_proc_q;

endmodule

// File: tb/tb_bus_arbiter_lv1_lv2.sv
// Self-checking bench for bus_arbiter_lv1_lv2: vector table, directed corner
// sequences and a randomized run against a behavioural model.
module tb_bus_arbiter_lv1_lv2;

`ifdef LV1_LV2_ARB_TIMEOUT_EN
   localparam int TB_TO    = 16;
   localparam bit TB_TO_EN = 1'b1;
`else
   localparam int TB_TO    = 1024;
   localparam bit TB_TO_EN = 1'b0;
`endif

   logic       clk, rst_n;
   logic [3:0] req_dl, req_il, req_snp;
   logic [3:0] gnt_dl, gnt_il, gnt_snp;
   logic       gnt_lv2, arb_to;
   logic [14:0] outs;

   int checks = 0;
   int errors = 0;

   bus_arbiter_lv1_lv2 #(.NUM_CORES(4), .TIMEOUT_CYC(TB_TO)) dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .bus_lv1_lv2_req_proc_dl (req_dl),
      .bus_lv1_lv2_req_proc_il (req_il),
      .bus_lv1_lv2_req_snoop   (req_snp),
      .bus_lv1_lv2_gnt_proc_dl (gnt_dl),
      .bus_lv1_lv2_gnt_proc_il (gnt_il),
      .bus_lv1_lv2_gnt_snoop   (gnt_snp),
      .bus_lv1_lv2_gnt_lv2     (gnt_lv2),
      .arb_timeout             (arb_to)
   );

   assign outs = {gnt_lv2, arb_to, gnt_snp, gnt_il, gnt_dl};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] dl, il, snp;
      logic [3:0] e_dl, e_il, e_snp;
      logic       e_lv2;
   } vec_t;

   vec_t vecs[20];

   // Behavioural model: owner / snoop owner as plain integers, -1 meaning none.
   int m_owner, m_snp, m_last_p, m_last_s, m_hold;
   bit m_rel, m_flag;

   task automatic model_reset();
      m_owner = -1; m_snp = -1; m_last_p = 7; m_last_s = 3;
      m_hold = 0; m_rel = 1'b0; m_flag = 1'b0;
   endtask

   task automatic model_step(input logic [3:0] dl, input logic [3:0] il, input logic [3:0] sn);
      bit req[8];
      bit own_req, to;
      int nxt_snp, pick;
      for (int i = 0; i < 8; i++) req[i] = (i % 2 == 1) ? il[i/2] : dl[i/2];
      if (m_rel) begin
         m_rel = 1'b0;
      end else if (m_owner < 0) begin
         for (int j = 1; j <= 8; j++)
            if (m_owner < 0 && req[(m_last_p + j) % 8]) m_owner = (m_last_p + j) % 8;
         if (m_owner >= 0) begin
            m_last_p = m_owner;
            m_hold   = 0;
         end
      end else begin
         own_req = req[m_owner];
         to      = TB_TO_EN && (m_hold == TB_TO - 1);
         nxt_snp = m_snp;
         if (m_snp >= 0) begin
            if (!sn[m_snp] || to) nxt_snp = -1;
         end else if (own_req && !to) begin
            pick = -1;
            for (int j = 1; j <= 4; j++)
               if (pick < 0 && sn[(m_last_s + j) % 4] && ((m_last_s + j) % 4 != m_owner / 2))
                  pick = (m_last_s + j) % 4;
            if (pick >= 0) begin
               nxt_snp  = pick;
               m_last_s = pick;
            end
         end
         if (to || (!own_req && m_snp < 0)) begin
            m_owner = -1;
            m_rel   = 1'b1;
         end else begin
            m_hold++;
         end
         if (to) m_flag = 1'b1;
         m_snp = nxt_snp;
      end
   endtask

   function automatic logic [14:0] model_outs();
      logic [3:0] dl, il, sn;
      for (int c = 0; c < 4; c++) begin
         dl[c] = (m_owner == 2*c);
         il[c] = (m_owner == 2*c + 1);
         sn[c] = (m_snp == c);
      end
      return {(m_owner >= 0), m_flag, sn, il, dl};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req_dl = '0; req_il = '0; req_snp = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   function automatic int grant_idx();
      int r;
      r = -1;
      for (int c = 0; c < 4; c++) begin
         if (gnt_dl[c]) r = 2*c;
         if (gnt_il[c]) r = 2*c + 1;
      end
      return r;
   endfunction

   initial begin
      int gap, got, n;
      rst_n = 1'b0; req_dl = '0; req_il = '0; req_snp = '0;

      //           dl       il       snp      e_dl     e_il     e_snp    lv2
      vecs[0]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b1};
      vecs[1]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
      vecs[2]  = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
      vecs[3]  = '{4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 1'b1};
      vecs[4]  = '{4'b0100, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 1'b1};
      vecs[5]  = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
      vecs[6]  = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
      vecs[7]  = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 1'b1};
      vecs[8]  = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
      vecs[9]  = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
      vecs[10] = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 1'b1};
      vecs[11] = '{4'b0010, 4'b0000, 4'b1010, 4'b0010, 4'b0000, 4'b1000, 1'b1};
      vecs[12] = '{4'b0000, 4'b0000, 4'b1010, 4'b0010, 4'b0000, 4'b1000, 1'b1};
      vecs[13] = '{4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 1'b1};
      vecs[14] = '{4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0};
      vecs[15] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
      vecs[16] = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b1};
      vecs[17] = '{4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1};
      vecs[18] = '{4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0};
      vecs[19] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};

      do_reset();
      check("reset_outs", 32'(outs), 32'(15'd0));

      for (int i = 0; i < 20; i++) begin
         req_dl = vecs[i].dl; req_il = vecs[i].il; req_snp = vecs[i].snp;
         tick();
         check($sformatf("vec%0d", i), 32'(outs),
               32'({vecs[i].e_lv2, 1'b0, vecs[i].e_snp, vecs[i].e_il, vecs[i].e_dl}));
      end

      // All eight requesters, each dropped after three grant cycles and re-raised.
      do_reset();
      req_dl = 4'hF; req_il = 4'hF;
      gap = 0;
      tick();
      for (int k = 0; k < 9; k++) begin
         while (!gnt_lv2 && gap < 10) begin
            gap++;
            tick();
         end
         got = grant_idx();
         check($sformatf("rr_order%0d", k), 32'(got), 32'(k % 8));
         // Gap after a release is the turnaround cycle plus the idle arbitration cycle.
         check($sformatf("rr_gap%0d", k), 32'(gap), (k == 0) ? 32'd0 : 32'd2);
         tick(); tick();
         check($sformatf("rr_hold%0d", k), 32'(grant_idx()), 32'(k % 8));
         if (k % 2 == 1) req_il[(k % 8) / 2] = 1'b0;
         else            req_dl[(k % 8) / 2] = 1'b0;
         tick();
         req_dl = 4'hF; req_il = 4'hF;
         gap = 0;
      end

      // Asynchronous reset in the middle of a grant.
      do_reset();
      req_dl = 4'b0100;
      tick();
      check("pre_rst_gnt", 32'(gnt_dl), 32'(4'b0100));
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_outs", 32'(outs), 32'(15'd0));
      req_dl = 4'b0001;
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      check("post_rst_gnt", 32'(outs), 32'({1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0001}));

      // Grant hold with the request never released.
      do_reset();
      req_dl = 4'b0001;
      tick();
`ifdef LV1_LV2_ARB_TIMEOUT_EN
      n = 0;
      while (gnt_dl[0] && n < 200) begin
         n++;
         tick();
      end
      check("to_len", 32'(n), 32'(TB_TO));
      check("to_flag", 32'(arb_to), 32'd1);
      repeat (5) tick();
      check("to_sticky", 32'(arb_to), 32'd1);
`else
      n = 0;
      for (int i = 0; i < 100; i++) begin
         if (gnt_dl[0]) n++;
         tick();
      end
      check("hold_100", 32'(n), 32'd100);
      check("no_timeout", 32'(arb_to), 32'd0);
`endif

      // Randomized run against the model.
      do_reset();
      model_reset();
      for (int i = 0; i < 600; i++) begin
         req_dl  = req_dl  ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
         req_il  = req_il  ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
         req_snp = req_snp ^ (4'($urandom) & 4'($urandom));
         model_step(req_dl, req_il, req_snp);
         tick();
         check($sformatf("rand%0d", i), 32'(outs), 32'(model_outs()));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
